// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: req/gnt request phase, rvalid response phase.
// The stage drives the master modport; the memory (or a bench model) takes the slave side.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one load/store at a time over req/gnt/rvalid, load alignment/extension, one WB pulse per op.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses complete with wb_err instead of being truncated.
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_size,
  input  logic [ADDR_W-1:0] ex_result,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  mem_access_stage_if.master mem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg;
  logic [2:0]        size_reg;
  logic [1:0]        off_reg;
  logic              is_wr_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_wstrb_reg;
  logic [4:0]        wb_rd_reg;
  logic [31:0]       wb_data_reg;
  logic              wb_err_reg;

  logic        is_mem, is_wr, sz_byte, sz_half, misaligned, trap;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic        resp_ok, timeout;
  logic [7:0]  rbyte [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Access decode on the EX inputs; only consumed on the accept cycle.
  assign is_mem     = ex_is_load | ex_is_store;
  assign is_wr      = ex_is_store & ~ex_is_load;
  assign sz_byte    = (ex_size == 3'b000) || (ex_size == 3'b100);
  assign sz_half    = (ex_size == 3'b001) || (ex_size == 3'b101);
  assign misaligned = (sz_half & ex_result[0]) |
                      (~sz_byte & ~sz_half & (ex_result[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem & misaligned;
`else
  assign trap = 1'b0 & misaligned;
`endif

  always_comb begin
    wstrb_next = 4'b1111;
    wdata_next = ex_wdata;
    if (sz_byte) begin
      wstrb_next = 4'b0001 << ex_result[1:0];
      wdata_next = {4{ex_wdata[7:0]}};
    end else if (sz_half) begin
      wstrb_next = 4'b0011 << {ex_result[1], 1'b0};
      wdata_next = {2{ex_wdata[15:0]}};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = mem.mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = rbyte[off_reg];
  assign ld_half = off_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    ld_fmt = mem.mem_rdata;
    case (size_reg)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = mem.mem_rdata;
    endcase
  end

  assign resp_ok = ((state_reg == REQ) & mem.mem_gnt & mem.mem_rvalid) |
                   ((state_reg == WAIT) & mem.mem_rvalid);
  assign timeout = (cnt_reg == TO_LAST);

  // Timeout beats a lone grant so the counter can never run past its last value.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ex_valid) state_next = (is_mem && !trap) ? REQ : DONE;
      REQ: begin
        if (resp_ok || timeout) state_next = DONE;
        else if (mem.mem_gnt)   state_next = WAIT;
      end
      WAIT: if (resp_ok || timeout) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      size_reg      <= 3'd0;
      off_reg       <= 2'd0;
      is_wr_reg     <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
      mem_wstrb_reg <= 4'd0;
      wb_rd_reg     <= 5'd0;
      wb_data_reg   <= 32'd0;
      wb_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (ex_valid) begin
          cnt_reg     <= 8'd0;
          size_reg    <= ex_size;
          off_reg     <= ex_result[1:0];
          is_wr_reg   <= is_wr;
          wb_rd_reg   <= ex_rd;
          wb_err_reg  <= trap;
          wb_data_reg <= is_mem ? 32'd0 : 32'(ex_result);
          if (is_mem && !trap) begin
            mem_addr_reg  <= {ex_result[ADDR_W-1:2], 2'b00};
            mem_we_reg    <= is_wr;
            mem_wdata_reg <= wdata_next;
            mem_wstrb_reg <= wstrb_next;
          end
        end
        REQ, WAIT: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (resp_ok) begin
            wb_data_reg <= is_wr_reg ? 32'd0 : ld_fmt;
            wb_err_reg  <= 1'b0;
          end else if (timeout) begin
            wb_data_reg <= 32'd0;
            wb_err_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_ready      = (state_reg == IDLE);
  assign mem.mem_req   = (state_reg == REQ);
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign wb_valid      = (state_reg == DONE);
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign wb_err        = wb_valid & wb_err_reg;

endmodule
